// File: rtl/miriscv_loader_pkg.sv
// Shared types for the UART boot loader.
// Loader FSM states, RX states and 8N1 frame constants.
package miriscv_loader_pkg;

    localparam int DATA_BITS = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERROR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/miriscv_uart_rx.sv
// 8N1 UART receiver with input synchroniser.
// Emits one-cycle byte_valid_o / frame_err_o pulses at the stop-bit sample.
module miriscv_uart_rx
    import miriscv_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] byte_o,
    output logic                 byte_valid_o,
    output logic                 frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST = BIT_W'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 meta_q, sync_q, prev_q;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    // Synchroniser, edge history and receiver state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit timing: mid-start check, then one sample per bit period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    valid_d = sync_q;
                    ferr_d  = !sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/miriscv_uart_loader.sv
// Boot loader: UART image -> RAM words, core held in reset until done.
// Image is a 16-bit LE word count followed by that many LE words.
module miriscv_uart_loader
    import miriscv_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 200_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int RAM_SIZE    = 512
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        uart_rx_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    output logic        core_rst_n_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int IDX_W        = $clog2(RAM_SIZE + 1);

    if (CLKS_PER_BIT < 4) begin : g_baud_chk
        $error("CLKS_PER_BIT must be at least 4");
    end

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ferr;

    ld_state_e        state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      len_full;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [23:0]      shift_q, shift_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, done_q, err_q;

    // Reset asserts immediately, releases on a clock edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    miriscv_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n),
        .rx_i         (uart_rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    // Loader state, word assembly and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LEN_LO;
            len_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= (state_d == WRITE);
            done_q  <= (state_d == DONE);
            err_q   <= (state_d == ERROR);
        end
    end

    assign len_full = {rx_byte, len_q[7:0]};

    // Next-state: length header, byte packing, one-cycle write.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_byte;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_d = len_full;
                    if ({16'd0, len_full} > 32'(RAM_SIZE)) begin
                        state_d = ERROR;
                    end else if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (bcnt_q == 2'(BYTES_PER_WORD - 1)) begin
                        bcnt_d  = '0;
                        wdata_d = {rx_byte, shift_q};
                        addr_d  = 32'(idx_q) << 2;
                        state_d = WRITE;
                    end else begin
                        bcnt_d  = bcnt_q + 1'b1;
                        shift_d = {rx_byte, shift_q[23:8]};
                    end
                end
            end
            WRITE: begin
                idx_d = idx_q + 1'b1;
                if (32'(idx_q) + 32'd1 == {16'd0, len_q}) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
        if (rx_ferr && state_q != DONE) begin
            state_d = ERROR;
        end
    end

    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_be_o     = 4'hF;
    assign core_rst_n_o = done_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_miriscv_uart_loader.sv
// Bench for the UART boot loader.
// Byte streams are checked against a word-list model of the image format.
module tb_miriscv_uart_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        core_rst_n;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int done_cyc = -1;
    bit done_seen = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done;
    bit          exp_err;
    int          exp_n;

    miriscv_uart_loader #(
        .CLK_FREQ_HZ (1_600_000),
        .BAUD_RATE   (100_000),
        .RAM_SIZE    (512)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .uart_rx_i    (uart_rx),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .core_rst_n_o (core_rst_n),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe and the first cycle done_o is seen high.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (!rst_n) begin
            done_seen = 0;
        end else if (done && !done_seen) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_mon();
        repeat (12) begin
            @(negedge clk);
            uart_rx = 1'($urandom_range(0, 1));
        end
        chk("rst.we", {31'd0, mem_we}, 0);
        chk("rst.addr", mem_addr, 0);
        chk("rst.wdata", mem_wdata, 0);
        chk("rst.be", {28'd0, mem_be}, 32'hF);
        chk("rst.core", {31'd0, core_rst_n}, 0);
        chk("rst.done", {31'd0, done}, 0);
        chk("rst.err", {31'd0, err}, 0);
        chk("rst.nwr", wr_addr.size(), 0);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(negedge clk);
        end
        stop_cyc = cyc;
        uart_rx = stop;
        repeat (16) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_img(input bq_t img);
        foreach (img[i]) begin
            send_byte(img[i], 1'b1);
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end
    endtask

    task automatic glitch();
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    // Image format model: header, then whole words until N reached.
    task automatic model(input bq_t img);
        int avail;
        int nw;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_n    = -1;
        if (img.size() < 2) return;
        exp_n = int'(img[0]) + 256 * int'(img[1]);
        if (exp_n > 512) begin
            exp_err = 1;
            return;
        end
        avail = (img.size() - 2) / 4;
        nw = (exp_n < avail) ? exp_n : avail;
        for (int w = 0; w < nw; w++) begin
            exp_addr.push_back(32'(4 * w));
            exp_data.push_back({img[2+4*w+3], img[2+4*w+2],
                                img[2+4*w+1], img[2+4*w]});
        end
        exp_done = (avail >= exp_n);
    endtask

    task automatic run_img(input string tag, input bq_t img, input bit rst);
        int nc;
        if (rst) do_reset();
        send_img(img);
        repeat (40) @(negedge clk);
        model(img);
        chk({tag, ".nwr"}, wr_addr.size(), exp_addr.size());
        nc = (wr_addr.size() < exp_addr.size()) ? wr_addr.size()
                                                : exp_addr.size();
        for (int i = 0; i < nc; i++) begin
            chk({tag, ".addr"}, wr_addr[i], exp_addr[i]);
            chk({tag, ".data"}, wr_data[i], exp_data[i]);
        end
        chk({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, ".core"}, {31'd0, core_rst_n}, {31'd0, exp_done});
        chk({tag, ".be"}, {28'd0, mem_be}, 32'hF);
        if (exp_done && exp_n > 0 && wr_cyc.size() > 0) begin
            chk({tag, ".lat"}, done_cyc - wr_cyc[$], 1);
        end
        if (exp_done && exp_n == 0 && img.size() == 2) begin
            chk({tag, ".lat0"},
                {31'd0, (done_cyc > stop_cyc && done_cyc <= stop_cyc + 16)},
                1);
        end
    endtask

    initial begin
        bq_t img;
        int  n;

        do_reset();

        img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h55};
        run_img("two_words", img, 1'b0);

        img = '{8'h00, 8'h00};
        run_img("n_zero", img, 1'b1);

        img = '{8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_img("n_513", img, 1'b1);

        do_reset();
        glitch();
        img = '{8'h00, 8'h00};
        run_img("glitch", img, 1'b0);
        send_byte(8'h41, 1'b0);
        repeat (20) @(negedge clk);
        chk("done_ferr.err", {31'd0, err}, 0);
        chk("done_ferr.done", {31'd0, done}, 1);

        do_reset();
        glitch();
        send_byte(8'h41, 1'b0);
        repeat (20) @(negedge clk);
        chk("ferr.err", {31'd0, err}, 1);
        chk("ferr.core", {31'd0, core_rst_n}, 0);
        chk("ferr.done", {31'd0, done}, 0);
        chk("ferr.nwr", wr_addr.size(), 0);

        img = '{8'h00, 8'h02};
        for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
        run_img("n_512", img, 1'b1);

        do_reset();
        img = '{8'h01, 8'h00, 8'h11};
        send_img(img);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
        do_reset();
        img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        run_img("mid_rst", img, 1'b0);

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 3);
            img = '{8'(n), 8'h00};
            for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
            if ($urandom_range(0, 2) == 0) void'(img.pop_back());
            else if ($urandom_range(0, 1) == 0) img.push_back(8'($urandom));
            run_img("rand", img, 1'b1);
        end

        n = $urandom_range(513, 65535);
        img = '{8'(n), 8'(n >> 8)};
        for (int i = 0; i < 4; i++) img.push_back(8'($urandom));
        run_img("rand_big", img, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
